// File: rtl/data_mem_responder.sv
// data_mem_responder: handshake responder for the data-memory request port.
// It holds a 2**ADDR_W x DATA_W store and serves one request at a time.
// After LATENCY wait states it performs the access and raises memAck for one
// cycle. A request with both memRead and memWrite high is flagged via memErr
// and does not touch the store.
`default_nettype none

module data_mem_responder #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] lineNumber,
   input  logic [DATA_W-1:0] memIn,
   output logic [DATA_W-1:0] memOut,
   output logic              memAck,
   output logic              memErr,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = 4;
   // The counter is loaded with LATENCY-1 so that the access lands on the
   // LATENCY-th edge after accept. A zero latency never uses the counter.
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              lat_rd;
   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              req;
   logic              acc_en;
   logic              acc_rd;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;

   assign req = memRead | memWrite;

   // Select the access for this edge: live inputs on a zero-latency accept,
   // otherwise the values latched at accept once the counter expires.
   always_comb begin
      acc_en   = 1'b0;
      acc_rd   = lat_rd;
      acc_wr   = lat_wr;
      acc_addr = lat_addr;
      acc_data = lat_data;
      if (state == IDLE && req && LATENCY == 0) begin
         acc_en   = 1'b1;
         acc_rd   = memRead;
         acc_wr   = memWrite;
         acc_addr = lineNumber;
         acc_data = memIn;
      end else if (state == WAIT && cnt == '0) begin
         acc_en = 1'b1;
      end
   end

   // Request FSM, storage and registered response outputs. Reset clears the
   // store and drops any in-flight request without committing it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_rd   <= 1'b0;
         lat_wr   <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
         memOut   <= '0;
         memAck   <= 1'b0;
         memErr   <= 1'b0;
         busy     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         memAck <= 1'b0;
         memErr <= 1'b0;

         // An illegal request (both ops) performs no storage access.
         if (acc_en) begin
            if (acc_rd && !acc_wr) begin
               memOut <= mem[acc_addr];
            end
            if (acc_wr && !acc_rd) begin
               mem[acc_addr] <= acc_data;
            end
         end

         case (state)
            IDLE: begin
               if (req) begin
                  lat_rd   <= memRead;
                  lat_wr   <= memWrite;
                  lat_addr <= lineNumber;
                  lat_data <= memIn;
                  busy     <= 1'b1;
                  if (LATENCY == 0) begin
                     state  <= RESP;
                     memAck <= 1'b1;
                     memErr <= memRead & memWrite;
                  end else begin
                     cnt   <= CNT_LOAD;
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state  <= RESP;
                  memAck <= 1'b1;
                  memErr <= lat_rd & lat_wr;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // Requests seen here are ignored; the requester re-issues.
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with LATENCY 2, 0 and 4,
// each with its own request inputs, checked against a per-instance array
// model of the store and of the last read value.
`timescale 1ns/1ps

module tb_data_mem_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] rd = '0;
   logic [2:0] wr = '0;
   logic [6:0] ln [3];
   logic [7:0] din [3];
   logic [7:0] mo [3];
   logic [2:0] ack;
   logic [2:0] err;
   logic [2:0] bsy;

   int checks = 0;
   int failures = 0;
   int lat [3] = '{2, 0, 4};
   logic [7:0] model [3][128];
   logic [7:0] mout [3];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(7), .DATA_W(8), .LATENCY(2)) u0 (
      .clk(clk), .rst_n(rst_n), .memRead(rd[0]), .memWrite(wr[0]),
      .lineNumber(ln[0]), .memIn(din[0]), .memOut(mo[0]),
      .memAck(ack[0]), .memErr(err[0]), .busy(bsy[0]));
   data_mem_responder #(.ADDR_W(7), .DATA_W(8), .LATENCY(0)) u1 (
      .clk(clk), .rst_n(rst_n), .memRead(rd[1]), .memWrite(wr[1]),
      .lineNumber(ln[1]), .memIn(din[1]), .memOut(mo[1]),
      .memAck(ack[1]), .memErr(err[1]), .busy(bsy[1]));
   data_mem_responder #(.ADDR_W(7), .DATA_W(8), .LATENCY(4)) u2 (
      .clk(clk), .rst_n(rst_n), .memRead(rd[2]), .memWrite(wr[2]),
      .lineNumber(ln[2]), .memIn(din[2]), .memOut(mo[2]),
      .memAck(ack[2]), .memErr(err[2]), .busy(bsy[2]));

   task automatic model_clear();
      for (int u = 0; u < 3; u++) begin
         mout[u] = 8'h00;
         for (int i = 0; i < 128; i++) model[u][i] = 8'h00;
      end
   endtask

   // One complete transaction on unit u, checked for latency, ack width,
   // error flag, busy and read data.
   task automatic txn(input int u, input bit r, input bit w,
                      input logic [6:0] a, input logic [7:0] d, input string nm);
      int k;
      logic exp_err;
      @(negedge clk);
      rd[u] = r; wr[u] = w; ln[u] = a; din[u] = d;
      @(posedge clk);
      @(negedge clk);
      rd[u] = 1'b0; wr[u] = 1'b0;
      ln[u] = 7'($urandom); din[u] = 8'($urandom);
      k = 0;
      while (!ack[u] && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (r && !w) mout[u] = model[u][a];
      if (w && !r) model[u][a] = d;
      exp_err = r & w;
      checks++;
      if (k !== lat[u]) begin
         failures++;
         $display("FAIL %s latency u%0d: got %0d edges, want %0d", nm, u, k, lat[u]);
      end
      checks++;
      if (err[u] !== exp_err) begin
         failures++;
         $display("FAIL %s memErr u%0d: got %b want %b", nm, u, err[u], exp_err);
      end
      checks++;
      if (mo[u] !== mout[u]) begin
         failures++;
         $display("FAIL %s memOut u%0d: got %02h want %02h", nm, u, mo[u], mout[u]);
      end
      checks++;
      if (bsy[u] !== 1'b1) begin
         failures++;
         $display("FAIL %s busy_with_ack u%0d: got %b want 1", nm, u, bsy[u]);
      end
      @(negedge clk);
      checks++;
      if (ack[u] !== 1'b0 || bsy[u] !== 1'b0 || err[u] !== 1'b0) begin
         failures++;
         $display("FAIL %s after_ack u%0d: ack=%b busy=%b err=%b want 0 0 0",
                  nm, u, ack[u], bsy[u], err[u]);
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (mo[u] !== 8'h00 || ack[u] !== 1'b0 || bsy[u] !== 1'b0 || err[u] !== 1'b0) begin
            failures++;
            $display("FAIL %s u%0d: memOut=%02h ack=%b busy=%b err=%b want 00 0 0 0",
                     nm, u, mo[u], ack[u], bsy[u], err[u]);
         end
      end
   endtask

   task automatic test_reset();
      for (int u = 0; u < 3; u++) begin ln[u] = '0; din[u] = '0; end
      model_clear();
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset_release");
      txn(0, 1, 0, 7'h7F, 8'h00, "reset_read_7f");
   endtask

   task automatic test_write_read_lat2();
      txn(0, 0, 1, 7'h12, 8'hA5, "l2_write");
      txn(0, 1, 0, 7'h12, 8'h00, "l2_read");
      txn(0, 0, 1, 7'h7F, 8'h5A, "l2_write_top");
      txn(0, 1, 0, 7'h7F, 8'h00, "l2_read_top");
   endtask

   task automatic test_lat0();
      txn(1, 0, 1, 7'h05, 8'h3C, "l0_write");
      txn(1, 1, 0, 7'h05, 8'h00, "l0_read");
      txn(1, 1, 1, 7'h05, 8'hEE, "l0_illegal");
      txn(1, 1, 0, 7'h05, 8'h00, "l0_read_after_err");
   endtask

   task automatic test_busy_ignore();
      int nacks;
      txn(0, 0, 1, 7'h02, 8'h9C, "bi_setup");
      @(negedge clk);
      wr[0] = 1'b1; ln[0] = 7'h01; din[0] = 8'h11;
      @(posedge clk);
      @(negedge clk);
      wr[0] = 1'b0; rd[0] = 1'b1; ln[0] = 7'h02; din[0] = 8'h00;
      nacks = 0;
      @(negedge clk);
      rd[0] = 1'b0;
      if (ack[0]) nacks++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[0]) nacks++;
      end
      model[0][1] = 8'h11;
      checks++;
      if (nacks !== 1) begin
         failures++;
         $display("FAIL busy_ignore ack_count: got %0d want 1", nacks);
      end
      checks++;
      if (mo[0] !== mout[0]) begin
         failures++;
         $display("FAIL busy_ignore memOut: got %02h want %02h", mo[0], mout[0]);
      end
      txn(0, 1, 0, 7'h02, 8'h00, "bi_read_02");
      txn(0, 1, 0, 7'h01, 8'h00, "bi_read_01");
   endtask

   task automatic test_illegal();
      txn(0, 0, 1, 7'h33, 8'hC3, "il_setup_w");
      txn(0, 1, 0, 7'h33, 8'h00, "il_setup_r");
      txn(0, 1, 1, 7'h20, 8'hFF, "il_both");
      txn(2, 1, 1, 7'h20, 8'hFF, "il_both_l4");
      txn(0, 1, 0, 7'h20, 8'h00, "il_read_20");
   endtask

   task automatic test_reset_mid_write();
      int seen;
      txn(2, 0, 1, 7'h40, 8'h55, "rm_setup");
      @(negedge clk);
      wr[2] = 1'b1; ln[2] = 7'h40; din[2] = 8'h77;
      @(posedge clk);
      @(negedge clk);
      wr[2] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_idle_outputs("reset_mid");
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack[2]) seen++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ack[2]) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_mid no_ack: got %0d acks want 0", seen);
      end
      txn(2, 1, 0, 7'h40, 8'h00, "rm_read_40");
      txn(0, 1, 0, 7'h12, 8'h00, "rm_read_l2");
   endtask

   task automatic test_random();
      int u;
      int op;
      logic [6:0] a;
      for (int n = 0; n < 60; n++) begin
         u  = int'($urandom_range(0, 2));
         op = int'($urandom_range(0, 9));
         a  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom);
         if (op < 5)      txn(u, 0, 1, a, 8'($urandom), "rand_write");
         else if (op < 9) txn(u, 1, 0, a, 8'h00, "rand_read");
         else             txn(u, 1, 1, a, 8'($urandom), "rand_illegal");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read_lat2();
      test_lat0();
      test_busy_ignore();
      test_illegal();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
